wb_stage: RTL
=============

# wb_stage

Write-back stage of the five-stage MIPS pipeline. It holds the MEM/WB pipeline register, extracts and extends load data according to the byte-select control, selects between ALU result, load data and link address, and drives the register-file write port (address, data, gated write enable) that the decode stage consumes. It also produces same-cycle WB→ID bypass flags, because the register file updates on the clock edge while decode reads combinationally.

## Interface
- No parameters.
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Stall  input  1  hold the MEM/WB register contents.
- Flush  input  1  load a bubble into the MEM/WB register.
- MEM_Valid  input  1  MEM stage holds a real instruction.
- MEM_RegWrite  input  1  instruction writes a register.
- MEM_MemToReg  input  1  1 selects load data, 0 selects ALU result.
- MEM_Link  input  1  1 selects the link address; overrides MemToReg.
- MEM_ByteSel  input  2  load width: 00 word, 01 half, 10 byte, 11 treated as word.
- MEM_SignExt  input  1  sign-extend (1) or zero-extend (0) sub-word loads.
- MEM_WriteAddr  input  5  destination register, already resolved by RegDst.
- MEM_ALUResult  input  32  ALU result; bits [1:0] also give the load byte offset.
- MEM_ReadData  input  32  raw word from data memory.
- MEM_PCI  input  32  PC+4 of the instruction.
- ID_ReadReg1  input  5  decode-stage rs field.
- ID_ReadReg2  input  5  decode-stage rt field.
- WriteAddr  output  5  register-file write address.
- WriteData  output  32  register-file write data.
- RW_AND  output  1  gated register-file write enable.
- Fwd1  output  1  WriteData must replace read port 1 in decode.
- Fwd2  output  1  WriteData must replace read port 2 in decode.

## Operation
- MEM/WB register fields: Valid, RegWrite, MemToReg, Link, ByteSel, SignExt, WriteAddr, ALUResult, ReadData, PCI.
- Register update priority on each rising edge: Flush > Stall > load.
  - Flush: Valid and RegWrite are cleared; other fields are don't-care.
  - Stall (without Flush): all fields hold.
  - Otherwise: all MEM_* inputs are captured.
- Load extraction from the registered ReadData, little-endian:
  - Byte: lane = ALUResult[1:0]; lane 0 is bits [7:0], lane 3 is bits [31:24].
  - Half: ALUResult[1] = 0 selects [15:0], 1 selects [31:16]; ALUResult[0] is ignored.
  - Word: ReadData unchanged.
  - Sub-word results are extended to 32 bits by sign or by zero, per the registered SignExt.
- WriteData selection: Link → PCI+4 (return address for JAL, i.e. instruction address+8); otherwise MemToReg → extracted load data; otherwise ALUResult. The adder is 32-bit and wraps.
- WriteAddr = registered WriteAddr.
- RW_AND = Valid & RegWrite & (WriteAddr != 0) & ~Stall. Writes to $0 are never issued.
- Fwd1 = RW_AND & (ID_ReadReg1 == WriteAddr). Fwd2 is the same with ID_ReadReg2. Both are purely combinational.

## Timing
- Latency: MEM inputs captured at edge N. WriteData, WriteAddr, RW_AND and Fwd are valid after edge N. The register file commits at edge N+1.
- Reset (asynchronous): every register field is 0. As a result WriteAddr = 0, WriteData = 0, RW_AND = 0, Fwd1 = 0, Fwd2 = 0.
- Stall held for k cycles: the output values are stable, RW_AND is low, and no duplicate write occurs. The write is issued in the first cycle after Stall drops.
- Flush and Stall asserted together: a bubble is loaded.
- Rst asserted mid-stall or mid-flush: the register clears immediately. After release, normal capture resumes on the first edge with Rst low.

## Configuration
- WB_RETIRE_COUNT_EN defined: adds output RetireCount [31:0], reset to 0. It increments on each rising edge where registered Valid = 1 and Stall = 0, so each instruction counts exactly once, bubbles excluded. It wraps from 0xFFFFFFFF to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then an ALU op with WriteAddr 5 and ALUResult 0x1234_5678 → one cycle later WriteData = 0x1234_5678, WriteAddr = 5, RW_AND = 1.
- Load byte, ReadData 0x80FF_7F01, ALUResult[1:0] = 3, SignExt = 1 → WriteData 0xFFFF_FF80. Same load with SignExt = 0 → 0x0000_0080. Half load with ALUResult[1] = 0 and SignExt = 1 → 0x0000_7F01.
- JAL (Link = 1, PCI 0x0040_0004, WriteAddr 31) → WriteData 0x0040_0008, RW_AND = 1. Instruction with WriteAddr 0 and RegWrite 1 → RW_AND = 0.
- Stall held 3 cycles over a valid write → RW_AND low for all 3 cycles, outputs unchanged, single write after release. Flush and Stall together → RW_AND = 0 next cycle.
- WriteAddr 9 writing with ID_ReadReg1 = 9 and ID_ReadReg2 = 10 → Fwd1 = 1, Fwd2 = 0. Same case with RegWrite = 0 → both flags 0.
- With WB_RETIRE_COUNT_EN: 4 valid instructions, 2 bubbles and a 2-cycle stall → RetireCount = 4. Assert Rst mid-sequence → RetireCount and all outputs are 0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction/extension, write-data select,
// gated register-file write enable and WB->ID bypass flags. Optional macro: WB_RETIRE_COUNT_EN.
module wb_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MEM_Valid,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemToReg,
  input  logic        MEM_Link,
  input  logic [1:0]  MEM_ByteSel,
  input  logic        MEM_SignExt,
  input  logic [4:0]  MEM_WriteAddr,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ReadData,
  input  logic [31:0] MEM_PCI,
  input  logic [4:0]  ID_ReadReg1,
  input  logic [4:0]  ID_ReadReg2,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic        RW_AND,
  output logic        Fwd1,
  output logic        Fwd2
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0] RetireCount
`endif
);

  logic        valid;
  logic        reg_write;
  logic        mem_to_reg;
  logic        link;
  logic [1:0]  byte_sel;
  logic        sign_ext;
  logic [4:0]  write_addr;
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic [31:0] pci;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  // A flush only needs to kill Valid/RegWrite; the payload is left as-is.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      link       <= 1'b0;
      byte_sel   <= 2'b00;
      sign_ext   <= 1'b0;
      write_addr <= 5'd0;
      alu_result <= 32'd0;
      read_data  <= 32'd0;
      pci        <= 32'd0;
    end else if (Flush) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
    end else if (!Stall) begin
      valid      <= MEM_Valid;
      reg_write  <= MEM_RegWrite;
      mem_to_reg <= MEM_MemToReg;
      link       <= MEM_Link;
      byte_sel   <= MEM_ByteSel;
      sign_ext   <= MEM_SignExt;
      write_addr <= MEM_WriteAddr;
      alu_result <= MEM_ALUResult;
      read_data  <= MEM_ReadData;
      pci        <= MEM_PCI;
    end
  end

  always_comb begin
    lane_byte = read_data[7:0];
    case (alu_result[1:0])
      2'd0:    lane_byte = read_data[7:0];
      2'd1:    lane_byte = read_data[15:8];
      2'd2:    lane_byte = read_data[23:16];
      default: lane_byte = read_data[31:24];
    endcase
    lane_half = alu_result[1] ? read_data[31:16] : read_data[15:0];
    case (byte_sel)
      2'b01:   load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
      2'b10:   load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      default: load_data = read_data;
    endcase
  end

  // Link returns instruction address + 8, i.e. the registered PC+4 plus another 4.
  always_comb begin
    if (link)
      WriteData = pci + 32'd4;
    else if (mem_to_reg)
      WriteData = load_data;
    else
      WriteData = alu_result;
  end

  assign WriteAddr = write_addr;
  assign RW_AND    = valid & reg_write & (write_addr != 5'd0) & ~Stall;
  assign Fwd1      = RW_AND & (ID_ReadReg1 == write_addr);
  assign Fwd2      = RW_AND & (ID_ReadReg2 == write_addr);

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      RetireCount <= 32'd0;
    else if (valid && !Stall)
      RetireCount <= RetireCount + 32'd1;
  end
`endif

endmodule
